// File: rtl/jk_sync_counter.sv
// jk_sync_counter: synchronous up/down/load counter whose state bits advance
// through JK excitation logic. Each cycle it computes the per-bit J/K pairs,
// applies the JK next-state rule to the state register q, and exposes the
// excitation bus so it can drive, or stand in for, a bank of JK flip-flops.
//
// Optional feature: define JK_CNT_MODULO_EN to wrap at MOD instead of 2^WIDTH.
//
// Parameters:
//   WIDTH  counter/state width in bits (2..16)
//   modulus parameter, used only with JK_CNT_MODULO_EN (2 <= MOD <= 2^WIDTH)
// Ports:
//   clk   rising-edge clock
//   r     synchronous active-high reset (priority over every mode)
//   mode  00 hold, 01 up, 10 down, 11 load
//   d     parallel load value, sampled when mode=11
//   q     registered counter state
//   jx    J excitation for the current cycle (combinational)
//   kx    K excitation for the current cycle (combinational)
//   tc    terminal count: the next enabled step wraps (combinational)
//   wrap  registered pulse, high for the cycle after a wrapping edge
module jk_sync_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             clk,
  input  logic             r,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] jx,
  output logic [WIDTH-1:0] kx,
  output logic             tc,
  output logic             wrap
);

  // Reject out-of-range configurations at elaboration.
  if (WIDTH < 2 || WIDTH > 16 || MOD < 2 || MOD > (32'd1 << WIDTH)) begin : g_param_err
    $error("jk_sync_counter: WIDTH or MOD out of range");
  end

  localparam logic [1:0] ModeHold = 2'b00;
  localparam logic [1:0] ModeUp   = 2'b01;
  localparam logic [1:0] ModeDown = 2'b10;
  localparam logic [1:0] ModeLoad = 2'b11;

`ifdef JK_CNT_MODULO_EN
  localparam logic [WIDTH-1:0] ModMax = WIDTH'(MOD - 1);
`endif

  logic [WIDTH-1:0] up_t;   // bit i toggles when counting up: &q[i-1:0]
  logic [WIDTH-1:0] dn_t;   // bit i toggles when counting down: &~q[i-1:0]
  logic             all_ones;
  logic             all_zero;
  logic [WIDTH-1:0] q_next;

  // Ripple-style prefix AND chains; bit 0 always toggles.
  always_comb begin
    logic up_acc;
    logic dn_acc;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    up_t   = '0;
    dn_t   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_acc;
      dn_t[i] = dn_acc;
      up_acc  = up_acc & q[i];
      dn_acc  = dn_acc & ~q[i];
    end
    all_ones = up_acc;
    all_zero = dn_acc;
  end

  always_comb begin
    jx = '0;
    kx = '0;
    tc = 1'b0;
    unique case (mode)
      ModeHold: begin
        jx = '0;
        kx = '0;
      end
      ModeUp: begin
`ifdef JK_CNT_MODULO_EN
        if (q >= ModMax) begin
          // Clear every set bit so the next state is 0.
          jx = '0;
          kx = q;
          tc = 1'b1;
        end else begin
          jx = up_t;
          kx = up_t;
        end
`else
        jx = up_t;
        kx = up_t;
        tc = all_ones;
`endif
      end
      ModeDown: begin
`ifdef JK_CNT_MODULO_EN
        if (all_zero) begin
          // Load MOD-1 through the excitation inputs.
          jx = ModMax;
          kx = ~ModMax;
        end else begin
          jx = dn_t;
          kx = dn_t;
        end
`else
        jx = dn_t;
        kx = dn_t;
`endif
        tc = all_zero;
      end
      ModeLoad: begin
        jx = d;
        kx = ~d;
      end
      default: begin
        jx = '0;
        kx = '0;
      end
    endcase
  end

  // JK rule per bit: J sets, K clears, both toggle, neither holds.
  assign q_next = (jx & ~q) | (~kx & q);

  // tc is only ever high in up/down, so load can never raise wrap.
  always_ff @(posedge clk) begin
    if (r) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= tc;
    end
  end

endmodule

// File: tb/tb_jk_sync_counter.sv
module tb_jk_sync_counter;

  localparam int unsigned WIDTH = 4;
`ifdef JK_CNT_MODULO_EN
  localparam int unsigned ExpMod = 10;
`else
  localparam int unsigned ExpMod = 16;
`endif

  logic             clk;
  logic             r;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] jx;
  logic [WIDTH-1:0] kx;
  logic             tc;
  logic             wrap;

  int n_vec;
  int n_err;

  jk_sync_counter #(
    .WIDTH (WIDTH),
    .MOD   (10)
  ) dut (
    .clk  (clk),
    .r    (r),
    .mode (mode),
    .d    (d),
    .q    (q),
    .jx   (jx),
    .kx   (kx),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs and let combinational outputs settle.
  task automatic drive(input logic rr, input logic [1:0] m, input logic [WIDTH-1:0] dv);
    r    = rr;
    mode = m;
    d    = dv;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    r     = 1'b1;
    mode  = 2'b11;
    d     = 4'hA;

    // Reset with load pending: reset wins.
    step();
    check("rst_q", 32'(q), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    drive(1'b0, 2'b01, 4'h0);
    check("rst_up_jx", 32'(jx), 32'h1);
    check("rst_up_kx", 32'(kx), 32'h1);
    check("rst_up_tc", 32'(tc), 32'h0);

    // Count up through a full modulus.
    for (int i = 0; i < int'(ExpMod); i++) begin
      check($sformatf("up_q%0d", i), 32'(q), 32'(i));
      check($sformatf("up_tc%0d", i), 32'(tc), 32'(i == int'(ExpMod) - 1));
      check($sformatf("up_wrap%0d", i), 32'(wrap), 32'h0);
      if (i == 3) begin
        check("up_jx3", 32'(jx), 32'h7);
        check("up_kx3", 32'(kx), 32'h7);
      end
      step();
    end
`ifdef JK_CNT_MODULO_EN
    check("up_wrapq", 32'(q), 32'h0);
`else
    check("up_wrapq", 32'(q), 32'h0);
`endif
    check("up_wrap_pulse", 32'(wrap), 32'h1);
    step();
    check("up_after_q", 32'(q), 32'h1);
    check("up_after_wrap", 32'(wrap), 32'h0);

    // Terminal-state excitation in up mode.
    drive(1'b0, 2'b11, 4'(ExpMod - 1));
    step();
    drive(1'b0, 2'b01, 4'h0);
`ifdef JK_CNT_MODULO_EN
    check("up_term_jx", 32'(jx), 32'h0);
    check("up_term_kx", 32'(kx), 32'h9);
`else
    check("up_term_jx", 32'(jx), 32'hF);
    check("up_term_kx", 32'(kx), 32'hF);
`endif
    check("up_term_tc", 32'(tc), 32'h1);

    // Down wrap from 0.
    drive(1'b0, 2'b11, 4'h0);
    step();
    check("ld0_q", 32'(q), 32'h0);
    check("ld0_wrap", 32'(wrap), 32'h0);
    drive(1'b0, 2'b10, 4'h0);
    check("dn_tc", 32'(tc), 32'h1);
`ifdef JK_CNT_MODULO_EN
    check("dn_jx", 32'(jx), 32'h9);
    check("dn_kx", 32'(kx), 32'h6);
`else
    check("dn_jx", 32'(jx), 32'hF);
    check("dn_kx", 32'(kx), 32'hF);
`endif
    step();
    check("dn_wrap_q", 32'(q), 32'(ExpMod - 1));
    check("dn_wrap_pulse", 32'(wrap), 32'h1);
    check("dn_tc_after", 32'(tc), 32'h0);
    step();
    check("dn_step_q", 32'(q), 32'(ExpMod - 2));
    check("dn_step_wrap", 32'(wrap), 32'h0);

`ifdef JK_CNT_MODULO_EN
    // Out-of-range load is accepted and decrements normally.
    drive(1'b0, 2'b11, 4'd12);
    step();
    check("oor_ld_q", 32'(q), 32'd12);
    drive(1'b0, 2'b10, 4'h0);
    check("oor_dn_tc", 32'(tc), 32'h0);
    step();
    check("oor_dn_q", 32'(q), 32'd11);
`endif

    // Load then hold.
    drive(1'b0, 2'b11, 4'd6);
    check("ld_tc", 32'(tc), 32'h0);
    check("ld_jx", 32'(jx), 32'h6);
    check("ld_kx", 32'(kx), 32'h9);
    step();
    check("ld6_q", 32'(q), 32'h6);
    drive(1'b0, 2'b00, 4'hF);
    check("hold_jx", 32'(jx), 32'h0);
    check("hold_kx", 32'(kx), 32'h0);
    check("hold_tc", 32'(tc), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_q%0d", i), 32'(q), 32'h6);
      check($sformatf("hold_wrap%0d", i), 32'(wrap), 32'h0);
    end

    // Loading terminal values, including a repeat load, never sets wrap.
    drive(1'b0, 2'b11, 4'hF);
    step();
    check("ldF_q", 32'(q), 32'hF);
    check("ldF_wrap", 32'(wrap), 32'h0);
    step();
    check("ldF2_wrap", 32'(wrap), 32'h0);
    drive(1'b0, 2'b11, 4'h0);
    step();
    check("ld0b_wrap", 32'(wrap), 32'h0);

    // Reset mid-operation beats a simultaneous load.
    drive(1'b0, 2'b11, 4'd7);
    step();
    check("ld7_q", 32'(q), 32'h7);
    drive(1'b1, 2'b11, 4'd12);
    step();
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_wrap", 32'(wrap), 32'h0);
    drive(1'b0, 2'b01, 4'd12);
    step();
    check("resume_q1", 32'(q), 32'h1);
    step();
    check("resume_q2", 32'(q), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
